// File: rtl/lcd_pio_master.sv
// Avalon-MM initiator that performs one HD44780-style LCD write per accepted
// command by sequencing writes to the RS, DATA and E PIO responders.
module lcd_pio_master #(
  parameter int unsigned E_PULSE_CYCLES = 12,
  parameter int unsigned SETTLE_CYCLES  = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] avm_address,
  output logic       avm_write_n,
  output logic [7:0] avm_writedata,
  output logic       cs_rs,
  output logic       cs_data,
  output logic       cs_e
);

  typedef enum logic [2:0] {
    IDLE, WR_RS, WR_DATA, WR_EHI, WAIT_E, WR_ELO, SETTLE
  } state_t;

  localparam logic [15:0] E_LOAD      = 16'(E_PULSE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  data_q;
  logic        ready_q, busy_q, done_q;
  logic        write_n_q, cs_rs_q, cs_data_q, cs_e_q;
  logic [7:0]  wdata_q;

  // Bus outputs are computed for the state being entered, so every output is
  // a flop and the write for a state appears in the cycle that state is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
      cs_rs_q   <= 1'b0;
      cs_data_q <= 1'b0;
      cs_e_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
      cs_rs_q   <= 1'b0;
      cs_data_q <= 1'b0;
      cs_e_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            data_q    <= cmd_data;
            state_q   <= WR_RS;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            cs_rs_q   <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= {7'b0, cmd_rs};
          end
        end
        WR_RS: begin
          state_q   <= WR_DATA;
          cs_data_q <= 1'b1;
          write_n_q <= 1'b0;
          wdata_q   <= data_q;
        end
        WR_DATA: begin
          state_q   <= WR_EHI;
          cs_e_q    <= 1'b1;
          write_n_q <= 1'b0;
          wdata_q   <= 8'h01;
        end
        WR_EHI: begin
          state_q <= WAIT_E;
          cnt_q   <= E_LOAD;
        end
        WAIT_E: begin
          if (cnt_q == 16'd0) begin
            state_q   <= WR_ELO;
            cs_e_q    <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= 8'h00;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        WR_ELO: begin
          state_q <= SETTLE;
          cnt_q   <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (cnt_q == 16'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign avm_address   = 2'b00;
  assign avm_write_n   = write_n_q;
  assign avm_writedata = wdata_q;
  assign cs_rs         = cs_rs_q;
  assign cs_data       = cs_data_q;
  assign cs_e          = cs_e_q;

endmodule

// File: tb/tb_lcd_pio_master.sv
// Directed bench for lcd_pio_master with E_PULSE_CYCLES=3, SETTLE_CYCLES=5,
// including models of the three PIO responders.
module tb_lcd_pio_master;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic [1:0] avm_address;
  logic       avm_write_n;
  logic [7:0] avm_writedata;
  logic       cs_rs;
  logic       cs_data;
  logic       cs_e;

  int vectors = 0;
  int miscompares = 0;

  lcd_pio_master #(.E_PULSE_CYCLES(3), .SETTLE_CYCLES(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata),
    .cs_rs(cs_rs), .cs_data(cs_data), .cs_e(cs_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder models: single register each, cleared by the shared reset.
  logic       rs_resp, e_resp;
  logic [7:0] data_resp;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_resp   <= 1'b0;
      data_resp <= 8'h00;
      e_resp    <= 1'b0;
    end else if (!avm_write_n) begin
      if (cs_rs)   rs_resp   <= avm_writedata[0];
      if (cs_data) data_resp <= avm_writedata;
      if (cs_e)    e_resp    <= avm_writedata[0];
    end
  end

  int cyc = 0;
  int acc_q[$];
  logic [7:0] dq[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (reset_n && !avm_write_n && cs_data) dq.push_back(avm_writedata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus protocol rules checked every cycle.
  always @(negedge clk) begin
    chk("proto_onehot", 32'($countones({cs_e, cs_data, cs_rs}) <= 1), 32'd1);
    chk("proto_wn", 32'(avm_write_n), 32'(!(cs_e | cs_data | cs_rs)));
    chk("proto_addr", 32'(avm_address), 32'd0);
    if (avm_write_n) chk("proto_wd_idle", 32'(avm_writedata), 32'd0);
  end

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Called at a negedge with the DUT idle; checks every cycle of one command.
  task automatic run_cmd(input logic rs, input logic [7:0] d);
    int ehigh = 0;
    logic [2:0] ecs;
    logic [7:0] ewd;
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        cmd_rs    = ~rs;
      end
      ecs = 3'b000;
      ewd = 8'h00;
      case (c)
        1: begin ecs = 3'b001; ewd = {7'b0, rs}; end
        2: begin ecs = 3'b010; ewd = d; end
        3: begin ecs = 3'b100; ewd = 8'h01; end
        7: begin ecs = 3'b100; ewd = 8'h00; end
        default: ;
      endcase
      $display("cycle %0d: cs=%b wd=%02h busy=%b ready=%b done=%b E=%b",
               c, {cs_e, cs_data, cs_rs}, avm_writedata, busy, cmd_ready, done, e_resp);
      chk("seq_cs", 32'({cs_e, cs_data, cs_rs}), 32'(ecs));
      chk("seq_wd", 32'(avm_writedata), 32'(ewd));
      chk("seq_busy", 32'(busy), 32'(c <= 12));
      chk("seq_ready", 32'(cmd_ready), 32'(c == 13));
      chk("seq_done", 32'(done), 32'(c == 13));
      if (e_resp) ehigh++;
    end
    chk("e_high_cycles", 32'(ehigh), 32'd4);
    chk("rs_resp", 32'(rs_resp), 32'(rs));
    chk("data_resp", 32'(data_resp), 32'(d));
  endtask

  int base, dbase;

  initial begin
    // Reset held with a pending command.
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wn", 32'(avm_write_n), 32'd1);
      chk("rst_wd", 32'(avm_writedata), 32'd0);
      chk("rst_cs", 32'({cs_e, cs_data, cs_rs}), 32'd0);
    end
    chk("rst_no_accept", 32'(acc_q.size()), 32'd0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    $display("single command rs=1 data=41");
    run_cmd(1'b1, 8'h41);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);

    // Back-to-back with cmd_valid held high.
    base = acc_q.size(); dbase = dq.size();
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h30;
    @(negedge clk);
    cmd_data = 8'h38;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_q.size() >= base + 2) break;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_q.size() - base), 32'd2);
    chk("b2b_gap", 32'(acc_q[base + 1] - acc_q[base]), 32'd13);
    wait_idle();
    chk("b2b_data0", 32'(dq[dbase]), 32'h30);
    chk("b2b_data1", 32'(dq[dbase + 1]), 32'h38);
    $display("back-to-back: accepts=%0d data %02h %02h", acc_q.size() - base, dq[dbase], dq[dbase + 1]);

    // Valid pulsed while busy must be ignored.
    @(negedge clk);
    base = acc_q.size(); dbase = dq.size();
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("busy_pulse_accepts", 32'(acc_q.size() - base), 32'd1);
    chk("busy_pulse_writes", 32'(dq.size() - dbase), 32'd1);
    chk("busy_pulse_data", 32'(dq[dbase]), 32'h5A);
    $display("pulse while busy: accepts=%0d", acc_q.size() - base);

    // Reset during WAIT_E.
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_e_high", 32'(e_resp), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'({cs_e, cs_data, cs_rs}), 32'd0);
    chk("mid_rst_wn", 32'(avm_write_n), 32'd1);
    chk("mid_rst_wd", 32'(avm_writedata), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_e", 32'(e_resp), 32'd0);
    $display("reset in WAIT_E: busy=%b E=%b", busy, e_resp);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("command after reset rs=1 data=C5");
    run_cmd(1'b1, 8'hC5);

    // Random traffic under the protocol monitor.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_rs    = 1'($urandom_range(0, 1));
      cmd_data  = 8'($urandom_range(0, 255));
    end
    cmd_valid = 1'b0;
    wait_idle();
    $display("random run: %0d accepts total", acc_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
